// File: rtl/spi_fifo_master.sv
// SPI mode-0 master that pops bytes from an upstream TX FIFO and shifts them
// out MSB first, capturing MISO into RX_DATA. Consecutive bytes are sent
// under one continuous CS_N low while ENABLE is high and the FIFO has data.
module spi_fifo_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [7:0] FIFO_DOUT,
  input  logic       FIFO_EMPTY,
  output logic       FIFO_RD_EN,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       CS_N,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    CS_SETUP,
    SHIFT,
    NEXT,
    CS_HOLD
  } state_t;

  state_t      state;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  tx_sr;
  logic [7:0]  rx_sr;
  logic        div_done;

  // Divider terminal count, shared by CS setup, SCLK half-periods and CS hold.
  assign div_done = (div_cnt == DIV_LAST);

  // Control FSM; every output is registered and changes with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      CS_N       <= 1'b1;
      SCLK       <= 1'b0;
      MOSI       <= 1'b0;
      FIFO_RD_EN <= 1'b0;
      RX_DATA    <= 8'h00;
      RX_VALID   <= 1'b0;
      BUSY       <= 1'b0;
      div_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
    end else begin
      FIFO_RD_EN <= 1'b0;
      RX_VALID   <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE && !FIFO_EMPTY) begin
            state      <= FETCH;
            FIFO_RD_EN <= 1'b1;
            BUSY       <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          MOSI    <= FIFO_DOUT[7];
          div_cnt <= 8'd0;
          bit_cnt <= 3'd0;
          if (CS_N) begin
            CS_N  <= 1'b0;
            state <= CS_SETUP;
          end else begin
            state <= SHIFT;
          end
        end
        CS_SETUP: begin
          if (div_done) begin
            div_cnt <= 8'd0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (div_done) begin
            div_cnt <= 8'd0;
            SCLK    <= ~SCLK;
            // Falling edge: advance MOSI, or finish the byte on the 8th one.
            if (SCLK) begin
              if (bit_cnt == 3'd7) begin
                bit_cnt  <= 3'd0;
                state    <= NEXT;
                RX_DATA  <= rx_sr;
                RX_VALID <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                MOSI    <= tx_sr[6];
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        NEXT: begin
          if (ENABLE && !FIFO_EMPTY) begin
            state      <= FETCH;
            FIFO_RD_EN <= 1'b1;
          end else begin
            state <= CS_HOLD;
          end
        end
        CS_HOLD: begin
          if (div_done) begin
            div_cnt <= 8'd0;
            CS_N    <= 1'b1;
            BUSY    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Data shift registers; always reloaded before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (state == LOAD) begin
      tx_sr <= FIFO_DOUT[6:0];
    end else if (state == SHIFT && div_done && SCLK) begin
      tx_sr <= {tx_sr[5:0], 1'b0};
    end
    if (state == SHIFT && div_done && !SCLK) begin
      rx_sr <= {rx_sr[6:0], MISO};
    end
  end

endmodule

// File: tb/tb_spi_fifo_master.sv
// Bench for spi_fifo_master: a FIFO model, an SPI slave model and cycle
// monitors feed a directed-plus-random sequence with immediate assertions.
module tb_spi_fifo_master;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ENABLE;
  logic [7:0] FIFO_DOUT = 8'h00;
  logic       FIFO_EMPTY = 1'b1;
  logic       FIFO_RD_EN;
  logic       SCLK;
  logic       MOSI;
  logic       MISO = 1'b0;
  logic       CS_N;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       BUSY;

  logic       b_enable;
  logic [7:0] b_fifo_dout;
  logic       b_fifo_empty = 1'b0;
  logic       b_rd;
  logic       b_sclk;
  logic       b_mosi;
  logic       b_miso;
  logic       b_cs_n;
  logic [7:0] b_rx_data;
  logic       b_rx_valid;
  logic       b_busy;

  spi_fifo_master #(.CLK_DIV(2)) u_dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .FIFO_DOUT(FIFO_DOUT),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD_EN(FIFO_RD_EN), .SCLK(SCLK),
    .MOSI(MOSI), .MISO(MISO), .CS_N(CS_N), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .BUSY(BUSY)
  );

  spi_fifo_master #(.CLK_DIV(255)) u_dut_slow (
    .CLK(CLK), .RST(RST), .ENABLE(b_enable), .FIFO_DOUT(b_fifo_dout),
    .FIFO_EMPTY(b_fifo_empty), .FIFO_RD_EN(b_rd), .SCLK(b_sclk),
    .MOSI(b_mosi), .MISO(b_miso), .CS_N(b_cs_n), .RX_DATA(b_rx_data),
    .RX_VALID(b_rx_valid), .BUSY(b_busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // upstream FIFO model: main writes fifo_mem/wr_ptr, monitor owns rd_ptr
  logic [7:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  // per-CS slave MISO pattern (byte j of a CS_N-low burst)
  logic [7:0] miso_pat [8];

  // monitor state
  int cyc = 0, rd_cnt = 0, pop_empty = 0, cs_fall = 0, cs_rise = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, rxv_cyc = 0, setup_gap = 0;
  int sclk_hi = 0, sclk_rise = 0, busy_cyc = 0;
  logic prev_cs_m = 1'b1, prev_sclk_m = 1'b0, rise_pend = 1'b0;
  logic [7:0] rx_got [$];
  logic [7:0] mosi_got [$];
  int b_rd_cnt = 0, b_rxv_cnt = 0;
  logic b_popped = 1'b0;

  // FIFO pops and DUT observation, away from the active edge
  always @(negedge CLK) begin
    cyc++;
    if (FIFO_RD_EN) begin
      rd_cnt++;
      if (rd_ptr == wr_ptr) pop_empty++;
      else begin
        FIFO_DOUT = fifo_mem[rd_ptr];
        rd_ptr++;
      end
    end
    FIFO_EMPTY = (rd_ptr == wr_ptr);
    if (RX_VALID) begin
      rx_got.push_back(RX_DATA);
      rxv_cyc = cyc;
    end
    if (!CS_N && prev_cs_m) begin
      cs_fall++;
      cs_fall_cyc = cyc;
      rise_pend = 1'b1;
    end
    if (CS_N && !prev_cs_m) begin
      cs_rise++;
      cs_rise_cyc = cyc;
    end
    if (SCLK) sclk_hi++;
    if (SCLK && !prev_sclk_m) begin
      sclk_rise++;
      if (rise_pend) begin
        setup_gap = cyc - cs_fall_cyc;
        rise_pend = 1'b0;
      end
    end
    if (BUSY) busy_cyc++;
    prev_cs_m = CS_N;
    prev_sclk_m = SCLK;
    if (b_rd) begin
      b_rd_cnt++;
      b_popped = 1'b1;
    end
    b_fifo_empty = b_popped;
    if (b_rx_valid) b_rxv_cnt++;
  end

  // SPI slave: samples MOSI on SCLK rise, presents MISO MSB first
  logic prev_cs_s = 1'b1, prev_sclk_s = 1'b0;
  int s_bit = 0, s_byte = 0, s_cnt = 0;
  logic [7:0] s_in = 8'h00;
  always @(CS_N or SCLK) begin
    if (CS_N === 1'b0 && prev_cs_s === 1'b1) begin
      s_bit = 0; s_byte = 0; s_cnt = 0; s_in = 8'h00;
      MISO = miso_pat[0][7];
    end else if (CS_N === 1'b0 && SCLK === 1'b1 && prev_sclk_s === 1'b0) begin
      s_in = {s_in[6:0], MOSI};
      s_cnt++;
      if (s_cnt == 8) begin
        mosi_got.push_back(s_in);
        s_cnt = 0;
      end
    end else if (CS_N === 1'b0 && SCLK === 1'b0 && prev_sclk_s === 1'b1) begin
      s_bit++;
      if (s_bit == 8) begin
        s_bit = 0;
        s_byte = (s_byte + 1) % 8;
      end
      MISO = miso_pat[s_byte][7 - s_bit];
    end
    prev_cs_s = CS_N;
    prev_sclk_s = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // bounded wait for one transfer session (BUSY high then low)
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (BUSY !== 1'b1 && n < 50) begin tick(1); n++; end
    chk({tag, "_busy_rise"}, BUSY, 1'b1);
    n = 0;
    while (BUSY !== 1'b0 && n < 20000) begin tick(1); n++; end
    chk({tag, "_busy_fall"}, BUSY, 1'b0);
    tick(2);
  endtask

  initial begin
    logic [7:0] tx [8];
    int rd0, rx0, mo0, cf0, cr0, sh0, sr0, bz0, n, nb;
    logic [7:0] left;

    RST = 1'b1; ENABLE = 1'b0; b_enable = 1'b0; b_fifo_dout = 8'hC3; b_miso = 1'b1;
    for (int i = 0; i < 8; i++) miso_pat[i] = 8'h00;
    tick(3);
    chk("rst_cs_n", CS_N, 1'b1);
    chk("rst_sclk", SCLK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_rd_en", FIFO_RD_EN, 1'b0);
    chk("rst_rx_data", RX_DATA, 8'h00);
    chk("rst_rx_valid", RX_VALID, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RST = 1'b0;
    tick(2);

    // single byte A5 out, 3C in
    rd0 = rd_cnt; rx0 = rx_got.size(); mo0 = mosi_got.size(); sh0 = sclk_hi; sr0 = sclk_rise;
    miso_pat[0] = 8'h3C;
    push(8'hA5);
    ENABLE = 1'b1;
    wait_done("s1");
    chk("s1_pops", rd_cnt - rd0, 1);
    chk("s1_rxv_cnt", rx_got.size() - rx0, 1);
    chk("s1_rx_data", rx_got[rx0], 8'h3C);
    chk("s1_mosi_byte", mosi_got[mo0], 8'hA5);
    chk("s1_sclk_rises", sclk_rise - sr0, 8);
    chk("s1_sclk_hi_cycles", sclk_hi - sh0, 16);
    chk("s1_setup_gap", setup_gap, 4);
    chk("s1_hold_gap", cs_rise_cyc - rxv_cyc, 3);
    chk("s1_mosi_hold", MOSI, 1'b1);
    chk("s1_sclk_idle", SCLK, 1'b0);
    chk("s1_cs_n_idle", CS_N, 1'b1);

    // three-byte burst under one CS_N low
    rd0 = rd_cnt; rx0 = rx_got.size(); mo0 = mosi_got.size(); cf0 = cs_fall; cr0 = cs_rise;
    tx[0] = 8'h01; tx[1] = 8'h80; tx[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      miso_pat[i] = 8'($urandom);
      push(tx[i]);
    end
    wait_done("s2");
    chk("s2_pops", rd_cnt - rd0, 3);
    chk("s2_rxv_cnt", rx_got.size() - rx0, 3);
    chk("s2_cs_falls", cs_fall - cf0, 1);
    chk("s2_cs_rises", cs_rise - cr0, 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s2_mosi%0d", i), mosi_got[mo0 + i], tx[i]);
      chk($sformatf("s2_rx%0d", i), rx_got[rx0 + i], miso_pat[i]);
    end

    // empty FIFO with ENABLE high: nothing happens
    rd0 = rd_cnt; bz0 = busy_cyc;
    tick(100);
    chk("s3_pops", rd_cnt - rd0, 0);
    chk("s3_busy_cycles", busy_cyc - bz0, 0);
    chk("s3_cs_n", CS_N, 1'b1);
    chk("s3_busy", BUSY, 1'b0);

    // ENABLE dropped during bit 3 of 55; second byte stays queued
    rd0 = rd_cnt; mo0 = mosi_got.size(); cr0 = cs_rise; sr0 = sclk_rise;
    left = 8'($urandom);
    miso_pat[0] = 8'($urandom);
    push(8'h55);
    push(left);
    n = 0;
    while ((sclk_rise - sr0) < 4 && n < 500) begin tick(1); n++; end
    chk("s4_reach_bit3", sclk_rise - sr0, 4);
    ENABLE = 1'b0;
    wait_done("s4");
    chk("s4_pops", rd_cnt - rd0, 1);
    chk("s4_mosi_cnt", mosi_got.size() - mo0, 1);
    chk("s4_mosi_byte", mosi_got[mo0], 8'h55);
    chk("s4_cs_rises", cs_rise - cr0, 1);
    chk("s4_left_queued", wr_ptr - rd_ptr, 1);
    tick(20);
    chk("s4_no_pop_after", rd_cnt - rd0, 1);

    // reset during bit 5 of the leftover byte, then a fresh transfer
    rd0 = rd_cnt; rx0 = rx_got.size(); mo0 = mosi_got.size(); sr0 = sclk_rise;
    miso_pat[0] = 8'($urandom);
    tx[0] = 8'($urandom);
    push(tx[0]);
    ENABLE = 1'b1;
    n = 0;
    while ((sclk_rise - sr0) < 6 && n < 500) begin tick(1); n++; end
    chk("s5_reach_bit5", sclk_rise - sr0, 6);
    RST = 1'b1;
    tick(1);
    chk("s5_rst_cs_n", CS_N, 1'b1);
    chk("s5_rst_sclk", SCLK, 1'b0);
    chk("s5_rst_busy", BUSY, 1'b0);
    chk("s5_rst_rxv", rx_got.size() - rx0, 0);
    RST = 1'b0;
    wait_done("s5");
    chk("s5_pops", rd_cnt - rd0, 2);
    chk("s5_rxv_cnt", rx_got.size() - rx0, 1);
    chk("s5_rx_data", rx_got[rx0], miso_pat[0]);
    chk("s5_mosi_cnt", mosi_got.size() - mo0, 1);
    chk("s5_mosi_byte", mosi_got[mo0], tx[0]);
    chk("s5_setup_gap", setup_gap, 4);

    // random bursts checked against byte-level expectations
    for (int r = 0; r < 4; r++) begin
      rd0 = rd_cnt; rx0 = rx_got.size(); mo0 = mosi_got.size(); cf0 = cs_fall;
      nb = $urandom_range(1, 4);
      for (int i = 0; i < nb; i++) begin
        tx[i] = 8'($urandom);
        miso_pat[i] = 8'($urandom);
        push(tx[i]);
      end
      wait_done($sformatf("r%0d", r));
      chk($sformatf("r%0d_pops", r), rd_cnt - rd0, nb);
      chk($sformatf("r%0d_cs_falls", r), cs_fall - cf0, 1);
      chk($sformatf("r%0d_rxv_cnt", r), rx_got.size() - rx0, nb);
      for (int i = 0; i < nb; i++) begin
        chk($sformatf("r%0d_mosi%0d", r, i), mosi_got[mo0 + i], tx[i]);
        chk($sformatf("r%0d_rx%0d", r, i), rx_got[rx0 + i], miso_pat[i]);
      end
    end
    chk("pop_while_empty", pop_empty, 0);

    // CLK_DIV=255: every SCLK half-period is 255 cycles
    begin
      int m, last, trans, good, csf, first_gap;
      logic prev, seen;
      logic [7:0] bmo;
      m = 0; last = 0; trans = 0; good = 0; csf = -1; first_gap = 0;
      prev = 1'b0; seen = 1'b0; bmo = 8'h00;
      b_enable = 1'b1;
      for (int i = 0; i < 6000; i++) begin
        tick(1);
        m++;
        if (b_busy) seen = 1'b1;
        if (b_cs_n == 1'b0 && csf < 0) csf = m;
        if (b_sclk !== prev) begin
          trans++;
          if (trans == 1) first_gap = m - csf;
          else if (m - last == 255) good++;
          if (b_sclk) bmo = {bmo[6:0], b_mosi};
          last = m;
          prev = b_sclk;
        end
        if (seen && !b_busy) break;
      end
      b_enable = 1'b0;
      tick(2);
      chk("slow_done", b_busy, 1'b0);
      chk("slow_transitions", trans, 16);
      chk("slow_half_periods", good, 15);
      chk("slow_setup_gap", first_gap, 510);
      chk("slow_mosi_byte", bmo, 8'hC3);
      chk("slow_rx_data", b_rx_data, 8'hFF);
      chk("slow_rxv_cnt", b_rxv_cnt, 1);
      chk("slow_pops", b_rd_cnt, 1);
      chk("slow_cs_n", b_cs_n, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
